// File: rtl/mrv32_mem_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and memory port B.
// Handshake: a request transfers on a cycle where mX_valid && mX_ready; the requester holds
// addr/wdata/wstrb stable while valid is high and ready is low. The memory side always accepts.
interface mrv32_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  m0_valid;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [31:0]           m0_wdata;
  logic [3:0]            m0_wstrb;
  logic                  m0_ready;
  logic [31:0]           m0_rdata;
  logic                  m0_rvalid;

  logic                  m1_valid;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [31:0]           m1_wdata;
  logic [3:0]            m1_wstrb;
  logic                  m1_lock;
  logic                  m1_ready;
  logic [31:0]           m1_rdata;
  logic                  m1_rvalid;

  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_rdata;
  logic                  mem_rvalid;

  logic                  err_mismatch;
  logic [1:0]            state;

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata, m0_rvalid,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    output m1_ready, m1_rdata, m1_rvalid,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_rvalid,
    output err_mismatch, state
  );

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata, m0_rvalid,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    input  m1_ready, m1_rdata, m1_rvalid,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_rvalid,
    input  err_mismatch, state
  );
endinterface

// File: rtl/mrv32_mem_arbiter.sv
// Two-requester arbiter for memory port B: per-cycle grant (round-robin or M0 priority),
// M1 bus lock, read-return routing through a tag pipe, and sticky rvalid mismatch detection.
module mrv32_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 2,
  parameter bit PRIO_MODE  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  mrv32_mem_arbiter_if.slave bus
);
  localparam int QW = $clog2(RD_LATENCY + 1);

  // S_LOCKED implies M1 was the last grant.
  typedef enum logic [1:0] {
    S_LAST_M0 = 2'd0,
    S_LAST_M1 = 2'd1,
    S_LOCKED  = 2'd2
  } arb_state_t;

  arb_state_t            state;
  arb_state_t            state_next;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rd_issue;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [RD_LATENCY-1:0] tag_rd;
  logic [RD_LATENCY-1:0] tag_own;
  logic                  tail_rd;
  logic                  tail_own;
  logic                  rv0;
  logic                  rv1;
  logic [QW-1:0]         quiet;
  logic                  err;

  always_ff @(posedge clk) begin
    if (rst) state <= S_LAST_M1;
    else     state <= state_next;
  end

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_next = state;
    if (!rst) begin
      // A lock only holds while M1 keeps m1_lock high; dropping it re-arbitrates at once.
      if (state == S_LOCKED && bus.m1_lock) begin
        gnt1 = bus.m1_valid;
      end else if (bus.m0_valid && bus.m1_valid) begin
        if (PRIO_MODE || state != S_LAST_M0) gnt0 = 1'b1;
        else                                 gnt1 = 1'b1;
      end else begin
        gnt0 = bus.m0_valid;
        gnt1 = bus.m1_valid;
      end

      if (gnt1)                                   state_next = bus.m1_lock ? S_LOCKED : S_LAST_M1;
      else if (gnt0)                              state_next = S_LAST_M0;
      else if (state == S_LOCKED && !bus.m1_lock) state_next = S_LAST_M1;
    end
  end

  always_comb begin
    addr_sel      = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    if (gnt0) begin
      addr_sel      = bus.m0_addr;
      bus.mem_wdata = bus.m0_wdata;
      bus.mem_wstrb = bus.m0_wstrb;
    end else if (gnt1) begin
      addr_sel      = bus.m1_addr;
      bus.mem_wdata = bus.m1_wdata;
      bus.mem_wstrb = bus.m1_wstrb;
    end
    bus.mem_addr  = addr_sel;
    bus.mem_valid = gnt0 | gnt1;
    bus.m0_ready  = gnt0;
    bus.m1_ready  = gnt1;
    rd_issue      = (gnt0 | gnt1) && (bus.mem_wstrb == 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_rd  <= '0;
      tag_own <= '0;
    end else begin
      tag_rd[0]  <= rd_issue;
      tag_own[0] <= gnt1;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_rd[i]  <= tag_rd[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

  assign tail_rd  = tag_rd[RD_LATENCY-1];
  assign tail_own = tag_own[RD_LATENCY-1];

  // Reads in flight at reset still come back; the quiet window hides them from the checker.
  always_ff @(posedge clk) begin
    if (rst) begin
      quiet <= QW'(RD_LATENCY);
      err   <= 1'b0;
    end else if (quiet != '0) begin
      quiet <= quiet - QW'(1);
    end else if (bus.mem_rvalid != tail_rd) begin
      err <= 1'b1;
    end
  end

  always_comb begin
    rv0              = !rst && bus.mem_rvalid && tail_rd && !tail_own;
    rv1              = !rst && bus.mem_rvalid && tail_rd && tail_own;
    bus.m0_rvalid    = rv0;
    bus.m1_rvalid    = rv1;
    bus.m0_rdata     = rv0 ? bus.mem_rdata : 32'h0;
    bus.m1_rdata     = rv1 ? bus.mem_rdata : 32'h0;
    bus.err_mismatch = err;
    bus.state        = state;
  end
endmodule
